// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports with write bypass,
// NWR write ports (highest index wins) and a pending-write scoreboard.
module regfile_mp #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 4,
    parameter int unsigned NWR  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWR-1:0]         we,
    input  logic [NWR*$clog2(NREG)-1:0] wa,
    input  logic [NWR*XLEN-1:0]    wd,
    input  logic [NRD*$clog2(NREG)-1:0] ra,
    output logic [NRD*XLEN-1:0]    rd,
    input  logic [NWR-1:0]         iss_en,
    input  logic [NWR*$clog2(NREG)-1:0] iss_dst,
    output logic [NRD-1:0]         rd_busy,
    output logic [NREG-1:0]        busy_vec
);

    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Later ports overwrite earlier ones, so the highest-index port wins on conflicts.
    always_comb begin
        for (int r = 0; r < int'(NREG); r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int i = 0; i < int'(NWR); i++) begin
            if (we[i] && (wa[i*AW +: AW] != '0)) begin
                regs_d[wa[i*AW +: AW]] = wd[i*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    // Clears applied first so that a same-cycle issue supersedes the writeback.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < int'(NWR); i++) begin
            if (we[i]) begin
                busy_d[wa[i*AW +: AW]] = 1'b0;
            end
        end
        for (int i = 0; i < int'(NWR); i++) begin
            if (iss_en[i]) begin
                busy_d[iss_dst[i*AW +: AW]] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(NREG); r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < int'(NREG); r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;
        logic            bsy;
        rd      = '0;
        rd_busy = '0;
        for (int j = 0; j < int'(NRD); j++) begin
            addr = ra[j*AW +: AW];
            val  = regs_q[addr];
            bsy  = busy_q[addr];
            for (int i = 0; i < int'(NWR); i++) begin
                if (we[i] && (wa[i*AW +: AW] == addr)) begin
                    val = wd[i*XLEN +: XLEN];
                    bsy = 1'b0;
                end
            end
            // Reset forces zero even against a live bypass.
            if (addr == '0 || rst) begin
                val = '0;
                bsy = 1'b0;
            end
            rd[j*XLEN +: XLEN] = val;
            rd_busy[j]         = bsy;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected values, a monitor compares them
// when a sample is requested mid-cycle.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    wa;
    logic [NWR*XLEN-1:0]  wd;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*XLEN-1:0]  rd;
    logic [NWR-1:0]       iss_en;
    logic [NWR*AW-1:0]    iss_dst;
    logic [NRD-1:0]       rd_busy;
    logic [NREG-1:0]      busy_vec;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .ra       (ra),
        .rd       (rd),
        .iss_en   (iss_en),
        .iss_dst  (iss_dst),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;   // 0: rd[idx], 1: busy_vec, 2: rd_busy[idx]
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    0:       act = rd[e.idx*XLEN +: XLEN];
                    1:       act = busy_vec;
                    default: act = {31'b0, rd_busy[e.idx]};
                endcase
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic exp_rd(input string n, input int j, input logic [31:0] v);
        sb.push_back('{name: n, kind: 0, idx: j, exp: v});
    endtask

    task automatic exp_busy(input string n, input logic [31:0] v);
        sb.push_back('{name: n, kind: 1, idx: 0, exp: v});
    endtask

    task automatic exp_rdb(input string n, input int j, input logic v);
        sb.push_back('{name: n, kind: 2, idx: j, exp: {31'b0, v}});
    endtask

    task automatic clear_in();
        we = '0; wa = '0; wd = '0; ra = '0; iss_en = '0; iss_dst = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
        clear_in();
    endtask

    task automatic sample();
        #3;
        ->sample_ev;
        #1;
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        we[p] = 1'b1;
        wa[p*AW +: AW] = a[AW-1:0];
        wd[p*XLEN +: XLEN] = d;
    endtask

    task automatic iss(input int p, input int a);
        iss_en[p] = 1'b1;
        iss_dst[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic rdp(input int j, input int a);
        ra[j*AW +: AW] = a[AW-1:0];
    endtask

    initial begin : timeout
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        clear_in();
        rst = 1'b1;
        #2;
        rdp(0, 1); rdp(1, 2); rdp(2, 3); rdp(3, 31);
        for (int j = 0; j < NRD; j++) begin
            exp_rd("reset_rd", j, 32'h0);
            exp_rdb("reset_rd_busy", j, 1'b0);
        end
        exp_busy("reset_busy_vec", 32'h0);
        sample();
        #2 rst = 1'b0;

        // x0 write and issue are ignored
        next_cycle();
        wr(0, 0, 32'hDEADBEEF); iss(0, 0); rdp(0, 0);
        exp_rd("x0_no_bypass", 0, 32'h0);
        sample();

        next_cycle();
        wr(0, 5, 32'h12345678); wr(1, 6, 32'hCAFEF00D); rdp(0, 0);
        exp_rd("x0_after_write", 0, 32'h0);
        exp_busy("x0_not_busy", 32'h0);
        sample();

        next_cycle();
        rdp(0, 5); rdp(1, 6); rdp(2, 5); rdp(3, 6);
        exp_rd("rd_r5_p0", 0, 32'h12345678);
        exp_rd("rd_r6_p1", 1, 32'hCAFEF00D);
        exp_rd("rd_r5_p2", 2, 32'h12345678);
        exp_rd("rd_r6_p3", 3, 32'hCAFEF00D);
        sample();

        // write conflict on r7: port 1 wins in bypass and storage
        next_cycle();
        wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); rdp(0, 7); rdp(1, 5);
        exp_rd("conflict_bypass", 0, 32'h2222);
        exp_rd("unrelated_r5", 1, 32'h12345678);
        sample();

        next_cycle();
        rdp(0, 7); iss(0, 9);
        exp_rd("conflict_stored", 0, 32'h2222);
        exp_busy("busy_before_edge", 32'h0);
        sample();

        next_cycle();
        rdp(1, 9);
        exp_busy("busy_r9_set", 32'h0000_0200);
        exp_rdb("rd_busy_r9", 1, 1'b1);
        sample();

        next_cycle();
        wr(0, 9, 32'hABCD0009); rdp(1, 9);
        exp_rdb("rd_busy_wb_same_cycle", 1, 1'b0);
        exp_rd("wb_bypass_r9", 1, 32'hABCD0009);
        exp_busy("busy_held_until_edge", 32'h0000_0200);
        sample();

        next_cycle();
        rdp(1, 9); iss(1, 9);
        exp_rd("r9_stored", 1, 32'hABCD0009);
        exp_rdb("rd_busy_r9_cleared", 1, 1'b0);
        exp_busy("busy_r9_cleared", 32'h0);
        sample();

        // set beats clear
        next_cycle();
        wr(0, 9, 32'h55AA55AA); iss(1, 9); rdp(2, 9);
        exp_busy("busy_reissued", 32'h0000_0200);
        exp_rd("set_clear_bypass", 2, 32'h55AA55AA);
        exp_rdb("set_clear_rd_busy", 2, 1'b0);
        sample();

        next_cycle();
        rdp(2, 9); iss(0, 3); iss(1, 9);
        exp_busy("set_beats_clear", 32'h0000_0200);
        exp_rdb("set_beats_clear_rdb", 2, 1'b1);
        exp_rd("set_clear_stored", 2, 32'h55AA55AA);
        sample();

        // async reset mid-cycle with state loaded
        next_cycle();
        rdp(0, 5); rdp(1, 6); rdp(2, 7); rdp(3, 9);
        exp_busy("waw_busy_vec", 32'h0000_0208);
        exp_rdb("waw_rd_busy", 3, 1'b1);
        sample();
        wr(0, 10, 32'h00000077);
        rst = 1'b1;
        #1;
        for (int j = 0; j < NRD; j++) begin
            exp_rd("async_rst_rd", j, 32'h0);
            exp_rdb("async_rst_rd_busy", j, 1'b0);
        end
        exp_busy("async_rst_busy", 32'h0);
        ->sample_ev;
        #1;

        // pending write during reset discarded; first edge after release writes
        @(posedge clk);
        #2;
        clear_in();
        rst = 1'b0;
        wr(0, 11, 32'h00001234);
        sample();

        next_cycle();
        rdp(0, 10); rdp(1, 11); rdp(2, 5);
        exp_rd("discarded_write", 0, 32'h0);
        exp_rd("first_edge_write", 1, 32'h00001234);
        exp_rd("r5_cleared", 2, 32'h0);
        sample();

        next_cycle();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
